rr_arb_mux: RTL and testbench
=============================

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 The module SHALL have parameter N, default 32, giving the data width per channel in bits (1..64).
REQ-002 The module SHALL have parameter CH, default 4, giving the input channel count (2..16); SW = max(1, clog2(CH)).
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 The module SHALL have port in_data, input, CH*N, with channel i occupying bits [i*N +: N].
REQ-006 The module SHALL have port in_valid, input, CH, giving per-channel valid.
REQ-007 The module SHALL have port in_ready, output, CH, giving per-channel accept; it is combinational.
REQ-008 The module SHALL have port mode, input, 1, where 0 selects fixed priority and 1 selects round-robin.
REQ-009 The module SHALL have port out_data, output, N, the registered selected data.
REQ-010 The module SHALL have port out_valid, output, 1, the registered output valid.
REQ-011 The module SHALL have port out_ready, input, 1, the downstream accept.
REQ-012 The module SHALL have port out_sel, output, SW, the registered index of the channel held in the output register.

Function
REQ-013 A transfer SHALL occur on any interface where valid and ready are both high at a rising clk edge.
REQ-014 load SHALL be defined as (!out_valid | out_ready), meaning the output register is free or draining this cycle.
REQ-015 At most one in_ready bit SHALL be high in any cycle; in_ready[i] = load & grant[i].
REQ-016 grant SHALL be one-hot among the in_valid bits, or zero when no in_valid bit is high.
REQ-017 In mode 0, grant SHALL go to the lowest-indexed valid channel.
REQ-018 In mode 1, grant SHALL go to the first valid channel at or after pointer ptr, searching upward with wrap from CH-1 to 0.
REQ-019 On a transfer from channel g, the register SHALL load out_data <= in_data[g], out_sel <= g, out_valid <= 1.
REQ-020 On a transfer from channel g in mode 1, ptr SHALL become (g+1) mod CH, wrapping CH-1 to 0.
REQ-021 In mode 0, ptr SHALL hold its value.
REQ-022 If load is high and no channel is valid, out_valid SHALL become 0; out_data and out_sel SHALL hold.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL hold stable, and all in_ready bits SHALL be 0 (backpressure).
REQ-024 Simultaneous drain and fill (out_valid=1, out_ready=1, a channel valid) SHALL load the new word in the same edge with no bubble; sustained throughput is 1 word/cycle.
REQ-025 Latency SHALL be 1 cycle from an input transfer to out_valid=1.
REQ-026 in_ready SHALL depend on in_valid, ptr, mode, out_valid and out_ready only; it SHALL never depend on in_data.
REQ-027 A mode change SHALL take effect in the same cycle's arbitration and SHALL NOT modify ptr.
REQ-028 in_data of a non-granted channel SHALL never reach out_data.
REQ-029 In mode 1 with all channels continuously valid and out_ready=1, the grant sequence SHALL be 0,1,...,CH-1,0,... (starvation-free).

Reset
REQ-030 While rst=1 at a rising edge, the block SHALL set out_valid=0, out_data=0, out_sel=0 and ptr=0.
REQ-031 While rst=1, in_ready SHALL be all-zero, and no input transfer SHALL be counted.
REQ-032 Asserting rst mid-transfer SHALL discard the held output word; the first post-reset grant in mode 1 SHALL start the search at channel 0.

Verification
REQ-033 Reset scenario: rst=1 for 2 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0.
REQ-034 Fixed-priority scenario: N=32, CH=4, mode=0, in_valid=4'b1010, data ch1=0x11111111, ch3=0x33333333, out_ready=1 -> out_sel=1 and out_data=0x11111111 every cycle; in_ready[3] stays 0.
REQ-035 Round-robin scenario: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
REQ-036 Backpressure scenario: out_valid=1 holding 0xDEADBEEF, out_ready=0 for 3 cycles while inputs change -> out_data stays 0xDEADBEEF and in_ready=0; then out_ready=1 -> a new word loads on the same edge.
REQ-037 Wrap/skip scenario: mode=1, ptr=3, in_valid=4'b0010 -> channel 1 is granted, and ptr becomes 2.
REQ-038 Mid-operation reset scenario: rst=1 for 1 cycle during RR traffic with ptr=2 -> next grant with in_valid=4'b1111 is channel 0.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: CH-channel arbiter and data mux into a single registered output stage.
// Arbitration is either fixed priority (lowest index wins) or round-robin from a rotating pointer.
// The output register accepts a new word whenever it is empty or being drained,
// which gives one word per cycle under continuous traffic.
module rr_arb_mux #(
    parameter int N  = 32,
    parameter int CH = 4,
    localparam int SW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*N-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [CH-1:0]   in_ready,
    input  logic            mode,
    output logic [N-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_sel
);

    logic [SW-1:0] ptr;
    logic          load;
    logic [CH-1:0] hi_valid;
    logic [CH-1:0] search;
    logic [CH-1:0] grant;
    logic [SW-1:0] gidx;
    logic [N-1:0]  gdata;
    logic          found;

    assign load     = !out_valid || out_ready;
    assign in_ready = (load && !rst) ? grant : '0;

    // Pick the granted channel: in round-robin mode prefer channels at or above ptr,
    // falling back to the lowest valid channel (the wrap); in fixed mode just the lowest.
    always_comb begin
        hi_valid = '0;
        grant    = '0;
        gidx     = '0;
        gdata    = '0;
        found    = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (mode && (i >= int'(ptr))) begin
                hi_valid[i] = in_valid[i];
            end
        end
        search = (|hi_valid) ? hi_valid : in_valid;
        for (int i = 0; i < CH; i++) begin
            if (search[i] && !found) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                gidx     = SW'(i);
                gdata    = in_data[i*N +: N];
            end
        end
    end

    // Output register and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (found) begin
                out_valid <= 1'b1;
                out_data  <= gdata;
                out_sel   <= gidx;
                if (mode) begin
                    ptr <= (gidx == SW'(CH - 1)) ? '0 : gidx + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux with a reference model and an expected-word scoreboard.
module tb_rr_arb_mux;

    localparam int N  = 32;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH*N-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic            mode;
    logic [N-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_sel;

    int checks = 0;
    int errors = 0;

    logic [33:0] sbq[$];
    int          m_ptr = 0;
    logic        m_ov  = 1'b0;

    rr_arb_mux #(.N(N), .CH(CH)) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .mode(mode),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sel(out_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        int idx;
        for (int k = 0; k < CH; k++) begin
            idx = mode ? (m_ptr + k) % CH : k;
            if (in_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_ch(input int i, input logic [31:0] v);
        in_data[i*N +: N] = v;
    endtask

    // One clock cycle: check combinational handshake, score the drained word,
    // advance the model, then check the registered valid after the edge.
    task automatic cycle();
        int          g;
        logic [CH-1:0] exp_rdy;
        logic        ld;
        logic [33:0] e;
        #2;
        ld = !m_ov || out_ready;
        g  = model_grant();
        exp_rdy = '0;
        if (!rst && ld && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (m_ov && out_ready) begin
            chk("sb_nonempty", 64'(sbq.size() > 0), 64'd1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("out_sel", 64'(out_sel), 64'(e[33:32]));
                chk("out_data", 64'(out_data), 64'(e[31:0]));
            end
        end
        if (rst) begin
            m_ov  = 1'b0;
            m_ptr = 0;
            sbq.delete();
        end else if (ld) begin
            if (g >= 0) begin
                sbq.push_back({2'(g), in_data[g*N +: N]});
                m_ov = 1'b1;
                if (mode) m_ptr = (g + 1) % CH;
            end else begin
                m_ov = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        for (int i = 0; i < CH; i++) set_ch(i, 32'hBAD0_0000 + i);

        // reset with all channels requesting
        cycle();
        cycle();
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_sel", 64'(out_sel), 64'd0);

        // fixed priority: channel 1 always beats channel 3
        rst      = 1'b0;
        in_valid = 4'b1010;
        set_ch(1, 32'h1111_1111);
        set_ch(3, 32'h3333_3333);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("fp_sel", 64'(out_sel), 64'd1);
            chk("fp_data", 64'(out_data), 64'h1111_1111);
        end

        // round-robin with all channels valid
        mode     = 1'b1;
        in_valid = 4'b1111;
        for (int i = 0; i < CH; i++) set_ch(i, 32'hA000_0000 + i);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("rr_seq", 64'(out_sel), 64'(k % 4));
        end

        // backpressure holding 0xDEADBEEF
        mode     = 1'b0;
        in_valid = 4'b0001;
        set_ch(0, 32'hDEAD_BEEF);
        cycle();
        chk("bp_load", 64'(out_data), 64'hDEAD_BEEF);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 4'b1110 >> k;
            for (int i = 0; i < CH; i++) set_ch(i, 32'h5000_0000 + 32'(k * 16 + i));
            cycle();
            chk("bp_hold", 64'(out_data), 64'hDEAD_BEEF);
        end
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        set_ch(2, 32'h2222_2222);
        cycle();
        chk("bp_release", 64'(out_data), 64'h2222_2222);

        // wrap/skip: ptr 0 -> grant 2 (ptr 3) -> only ch1 valid, grant 1 (ptr 2)
        mode     = 1'b1;
        in_valid = 4'b0100;
        cycle();
        in_valid = 4'b0010;
        set_ch(1, 32'h0101_0101);
        cycle();
        chk("wrap_sel", 64'(out_sel), 64'd1);

        // reset mid-traffic with ptr at 2; search must restart at channel 0
        rst      = 1'b1;
        in_valid = 4'b1111;
        cycle();
        rst = 1'b0;
        cycle();
        chk("post_rst_sel", 64'(out_sel), 64'd0);

        // drain
        in_valid = 4'b0000;
        cycle();
        cycle();
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
